// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives a synchronous-read instruction ROM and hands words to
// decode through a 2-entry FIFO, with branch redirects and terminator halt.
module fetch_sequencer #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_INST = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_rdata,
    output logic              inst_valid,
    output logic [WIDTH-1:0]  inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_INST);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic [1:0]        count;
    logic              inflight;
    logic              halt_seen;
    logic              drop;
    logic [WIDTH-1:0]  data0, data1;
    logic [ADDR_W-1:0] pc0, pc1;

    logic pop;
    logic push;
    logic pc_in_range;
    logic fifo_room;
    logic issue;
    logic drained;

    assign pop         = inst_valid & inst_ready;
    assign pc_in_range = {1'b0, pc} < LIMIT;
    // Slots already claimed (held + in flight) minus the one leaving this cycle.
    assign fifo_room   = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign issue       = (state == FETCH) & !redirect_valid & !halt_seen & pc_in_range & fifo_room;
    assign push        = inflight & !drop & !halt_seen;
    assign drained     = !inflight & ((count == 2'd0) | ((count == 2'd1) & pop));

    assign imem_en    = issue;
    assign imem_addr  = pc;
    assign inst_valid = (count != 2'd0);
    assign inst       = data0;
    assign inst_pc    = pc0;
    assign busy       = (state == FETCH);
    assign done       = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            req_pc    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            halt_seen <= 1'b0;
            drop      <= 1'b0;
            data0     <= '0;
            data1     <= '0;
            pc0       <= '0;
            pc1       <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    inflight <= 1'b0;
                    drop     <= 1'b0;
                    if (start) begin
                        state     <= FETCH;
                        pc        <= start_pc;
                        count     <= '0;
                        halt_seen <= 1'b0;
                    end
                end
                FETCH: begin
                    inflight <= issue;
                    drop     <= 1'b0;
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        count     <= '0;
                        halt_seen <= 1'b0;
                        drop      <= 1'b1;
                    end else begin
                        if (issue) begin
                            pc     <= pc + ADDR_W'(1);
                            req_pc <= pc;
                        end
                        case ({push, pop})
                            2'b10: begin
                                if (count == 2'd0) begin
                                    data0 <= imem_rdata;
                                    pc0   <= req_pc;
                                end else begin
                                    data1 <= imem_rdata;
                                    pc1   <= req_pc;
                                end
                                count <= count + 2'd1;
                            end
                            2'b01: begin
                                data0 <= data1;
                                pc0   <= pc1;
                                count <= count - 2'd1;
                            end
                            2'b11: begin
                                // Simultaneous push/pop: the new word lands behind any remaining entry.
                                if (count == 2'd2) begin
                                    data0 <= data1;
                                    pc0   <= pc1;
                                    data1 <= imem_rdata;
                                    pc1   <= req_pc;
                                end else begin
                                    data0 <= imem_rdata;
                                    pc0   <= req_pc;
                                end
                            end
                            default: ;
                        endcase
                        if (push && imem_rdata == '0)
                            halt_seen <= 1'b1;
                        if ((halt_seen | !pc_in_range) & drained)
                            state <= HALT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: an expected-delivery-stream model checked every cycle,
// directed scenarios with literal expectations, then randomized programs.
module tb_fetch_sequencer;

    localparam int WIDTH    = 32;
    localparam int ADDR_W   = 8;
    localparam int NUM_INST = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [WIDTH-1:0]  imem_rdata;
    logic              inst_valid;
    logic [WIDTH-1:0]  inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              busy;
    logic              done;

    fetch_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_INST(NUM_INST)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rom [NUM_INST];

    // Synchronous-read ROM; garbage when not strobed so stray captures show up.
    always @(posedge clk)
        imem_rdata <= (imem_en && int'(imem_addr) < NUM_INST) ? rom[int'(imem_addr)] : $urandom;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected delivery stream: indices from the entry point up to the first zero word or NUM_INST.
    int               exp_pc[$];
    logic [WIDTH-1:0] exp_w[$];
    bit               fetching = 1'b0;
    bit               prev_stall = 1'b0;
    bit               after_redirect = 1'b0;
    int               empty_wait = 0;
    logic [WIDTH-1:0]  prev_inst;
    logic [ADDR_W-1:0] prev_pc;
    int               en_total = 0;
    int               pop_total = 0;

    logic              snap_en, snap_valid, snap_done, snap_busy, snap_pop;
    logic [ADDR_W-1:0] snap_addr, snap_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build(input logic [ADDR_W-1:0] p);
        exp_pc.delete();
        exp_w.delete();
        for (int i = int'(p); i < NUM_INST; i++) begin
            exp_pc.push_back(i);
            exp_w.push_back(rom[i]);
            if (rom[i] == '0) break;
        end
    endtask

    task automatic model_reset();
        fetching = 1'b0;
        exp_pc.delete();
        exp_w.delete();
        prev_stall = 1'b0;
        after_redirect = 1'b0;
        empty_wait = 0;
    endtask

    task automatic model_check();
        logic popping;
        if (rst) return;
        snap_en    = imem_en;
        snap_addr  = imem_addr;
        snap_valid = inst_valid;
        snap_pc    = inst_pc;
        snap_done  = done;
        snap_busy  = busy;
        popping    = inst_valid && inst_ready && !redirect_valid;
        snap_pop   = popping && fetching;
        if (imem_en) begin
            en_total++;
            chk("imem_addr_range", 64'(int'(imem_addr) < NUM_INST), 64'd1);
        end
        if (!fetching) begin
            chk("quiet_when_stopped", {imem_en, inst_valid, busy}, 64'd0);
            if (start) begin
                fetching = 1'b1;
                build(start_pc);
                empty_wait = 0;
                prev_stall = 1'b0;
                after_redirect = 1'b0;
            end
            return;
        end
        if (after_redirect) chk("flush_after_redirect", inst_valid, 64'd0);
        after_redirect = 1'b0;
        if (prev_stall) chk("stall_hold", {inst_valid, inst_pc, inst}, {1'b1, prev_pc, prev_inst});
        prev_stall = inst_valid && !inst_ready && !redirect_valid;
        prev_pc    = inst_pc;
        prev_inst  = inst;
        if (redirect_valid) begin
            build(redirect_pc);
            after_redirect = 1'b1;
            empty_wait = 0;
            return;
        end
        if (exp_pc.size() != 0) begin
            chk("busy_not_done", {busy, done}, 64'b10);
            if (popping) begin
                chk("pop_pc", 64'(inst_pc), 64'(exp_pc.pop_front()));
                chk("pop_inst", 64'(inst), 64'(exp_w.pop_front()));
                pop_total++;
            end
        end else begin
            if (popping) chk("no_pop_after_stream", inst_valid, 64'd0);
            if (done) begin
                chk("halt_latency", 64'(empty_wait <= 3), 64'd1);
                fetching = 1'b0;
            end else begin
                empty_wait++;
                if (empty_wait > 5) begin
                    chk("halt_timeout", done, 64'd1);
                    fetching = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_stopped();
        for (int i = 0; i < 60 && fetching; i++) cycle();
        if (fetching) begin
            chk("wait_stopped", fetching, 64'd0);
            model_reset();
        end
    endtask

    task automatic load_rom_basic();
        for (int i = 0; i < NUM_INST - 1; i++) rom[i] = 32'h100 + 32'h1111 * i;
        rom[NUM_INST-1] = '0;
    endtask

    task automatic kick(input logic [ADDR_W-1:0] p);
        start_pc = p;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int first_en, first_pop, last_pop, done_k, en0, p0, first_pc;
        bit found;

        rst = 1'b1; start = 1'b0; start_pc = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        load_rom_basic();
        #3;
        chk("reset_flags", {inst_valid, imem_en, busy, done}, 64'd0);
        chk("reset_values", {inst_pc, inst, imem_addr}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Full program at one instruction per cycle.
        inst_ready = 1'b1;
        en0 = en_total; p0 = pop_total;
        first_en = -1; first_pop = -1; last_pop = -1; done_k = -1;
        kick(0);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (snap_en && first_en < 0) first_en = k;
            if (snap_pop) begin
                if (first_pop < 0) first_pop = k;
                last_pop = k;
            end
            if (snap_done && done_k < 0) done_k = k;
        end
        chk("t1_first_en", 64'(first_en), 64'd1);
        chk("t1_en_count", 64'(en_total - en0), 64'd13);
        chk("t1_first_pop", 64'(first_pop), 64'd3);
        chk("t1_last_pop", 64'(last_pop), 64'd15);
        chk("t1_pop_count", 64'(pop_total - p0), 64'd13);
        chk("t1_done_cycle", 64'(done_k), 64'd16);

        // Decode stall for four cycles.
        p0 = pop_total;
        kick(0);
        for (int k = 1; k <= 24; k++) begin
            inst_ready = !(k >= 4 && k <= 7);
            cycle();
            if (k >= 4 && k <= 7) chk("t2_stall_no_issue", snap_en, 64'd0);
            if (k == 7) chk("t2_stall_head_pc", 64'(snap_pc), 64'd1);
        end
        inst_ready = 1'b1;
        chk("t2_pop_count", 64'(pop_total - p0), 64'd13);
        wait_stopped();

        // Redirect to 9 while head is index 3.
        kick(0);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (inst_valid && inst_pc == 8'd3) begin
                found = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc = 8'd9;
                cycle();
                redirect_valid = 1'b0;
            end else cycle();
        end
        chk("t3_redirect_window", found, 64'd1);
        p0 = pop_total;
        cycle();
        chk("t3_flush", snap_valid, 64'd0);
        chk("t3_first_issue", {snap_en, snap_addr}, {1'b1, 8'd9});
        first_pc = -1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (snap_pop && first_pc < 0) first_pc = int'(snap_pc);
        end
        chk("t3_first_pc", 64'(first_pc), 64'd9);
        chk("t3_pop_count", 64'(pop_total - p0), 64'd4);
        wait_stopped();

        // Early terminator at index 5.
        rom[5] = '0;
        p0 = pop_total; last_pop = -1;
        kick(0);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (snap_pop) last_pop = int'(snap_pc);
        end
        chk("t4_pop_count", 64'(pop_total - p0), 64'd6);
        chk("t4_last_pc", 64'(last_pop), 64'd5);
        chk("t4_done", snap_done, 64'd1);
        load_rom_basic();

        // Redirect out of range, then restart at 2.
        kick(0);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (inst_valid && inst_pc == 8'd4) begin
                found = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc = 8'd20;
                cycle();
                redirect_valid = 1'b0;
            end else cycle();
        end
        chk("t5_redirect_window", found, 64'd1);
        en0 = en_total;
        for (int k = 0; k < 6; k++) cycle();
        chk("t5_no_issue", 64'(en_total - en0), 64'd0);
        chk("t5_done", snap_done, 64'd1);
        kick(2);
        first_pc = -1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (snap_pop && first_pc < 0) first_pc = int'(snap_pc);
        end
        chk("t5_restart_pc", 64'(first_pc), 64'd2);
        wait_stopped();

        // Asynchronous reset mid-stream.
        kick(0);
        for (int k = 0; k < 6 && !inst_valid; k++) cycle();
        chk("t6_pre_reset_active", {inst_valid, busy}, 64'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_reset_immediate", {inst_valid, imem_en, busy, done}, 64'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("t6_idle_after_reset", {snap_busy, snap_done, snap_en}, 64'd0);

        // Randomized programs, stalls and redirects.
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < NUM_INST; i++)
                rom[i] = ($urandom_range(0, 9) == 0) ? '0 : ($urandom | 32'h1);
            kick(ADDR_W'($urandom_range(0, 15)));
            for (int k = 0; k < 80 && fetching; k++) begin
                inst_ready = ($urandom_range(0, 9) < 7);
                if (exp_pc.size() != 0 && $urandom_range(0, 24) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc = ADDR_W'($urandom_range(0, 15));
                end
                cycle();
                redirect_valid = 1'b0;
            end
            chk("rand_stream_end", fetching, 64'd0);
            model_reset();
            inst_ready = 1'b1;
            cycle();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
